// File: rtl/nettlp_pkg.sv
// Shared NetTLP definitions: Ethernet TX source indices, arbiter defaults,
// arbiter state encoding and a saturating counter helper.
package nettlp_pkg;

  localparam int ETH_TX_SRC_TLP     = 0;
  localparam int ETH_TX_SRC_CMD     = 1;
  localparam int ETH_TX_SRC_PCIECFG = 2;
  localparam int ETH_TX_NUM_SRC     = 3;
  localparam int ETH_TX_MAX_BEATS   = 200;
  localparam int ETH_TX_IDX_W       = 2;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2
  } eth_tx_arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// Source-side AXI-Stream bundle plus the MAC TX stream of the Ethernet TX arbiter.
interface eth_tx_arbiter_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tready;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC*8-1:0]  s_tkeep;
  logic [NUM_SRC*64-1:0] s_tdata;
  logic                  eth_tready;
  logic                  eth_tvalid;
  logic                  eth_tlast;
  logic                  eth_tuser;
  logic [7:0]            eth_tkeep;
  logic [63:0]           eth_tdata;

  // master = sources and MAC environment, slave = the arbiter
  modport master (
    output s_tvalid, s_tlast, s_tkeep, s_tdata, eth_tready,
    input  s_tready, eth_tvalid, eth_tlast, eth_tuser, eth_tkeep, eth_tdata
  );

  modport slave (
    input  s_tvalid, s_tlast, s_tkeep, s_tdata, eth_tready,
    output s_tready, eth_tvalid, eth_tlast, eth_tuser, eth_tkeep, eth_tdata
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rr_pick
  import nettlp_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]              req,
  input  logic [ETH_TX_IDX_W-1:0]   ptr,
  output logic [N-1:0]              grant_oh,
  output logic [ETH_TX_IDX_W-1:0]   grant_idx
);

  // Scan farthest-to-nearest so the candidate right after ptr overrides the rest.
  always_comb begin
    int cand;
    logic [ETH_TX_IDX_W-1:0] cand_idx;
    grant_oh  = '0;
    grant_idx = '0;
    for (int k = N; k >= 1; k--) begin
      cand      = (int'(ptr) + k) % N;
      cand_idx  = ETH_TX_IDX_W'(cand);
      grant_oh  = req[cand_idx] ? ({{(N-1){1'b0}}, 1'b1} << cand_idx) : grant_oh;
      grant_idx = req[cand_idx] ? cand_idx : grant_idx;
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular arbiter sharing the 64-bit Ethernet TX stream between frame
// sources, with strict-priority class, round-robin fairness and beat-limit abort.
module eth_tx_arbiter
  import nettlp_pkg::*;
#(
  parameter int                 NUM_SRC   = ETH_TX_NUM_SRC,
  parameter logic [NUM_SRC-1:0] PRIO_MASK = 3'b010,
  parameter int                 MAX_BEATS = ETH_TX_MAX_BEATS
) (
  input  logic                    eth_clk,
  input  logic                    eth_rst,
  eth_tx_arbiter_if.slave         bus,
  output logic [ETH_TX_IDX_W-1:0] grant_idx,
  output logic [15:0]             abort_count
);

  localparam logic [8:0] LAST_BEAT = 9'(MAX_BEATS - 1);

  eth_tx_arb_state_e       state_r, state_s;
  logic [ETH_TX_IDX_W-1:0] grant_idx_r, rr_ptr_r, pr_idx_s, all_idx_s, win_idx_s;
  logic [NUM_SRC-1:0]      gnt_oh_r, pr_req_s, pr_oh_s, all_oh_s, win_oh_s;
  logic [8:0]              beat_cnt_r;
  logic [15:0]             abort_count_r;
  logic                    g_valid_s, g_last_s, xfer_s, at_limit_s, any_req_s;

  assign pr_req_s  = bus.s_tvalid & PRIO_MASK;
  assign any_req_s = |bus.s_tvalid;

  rr_pick #(.N(NUM_SRC)) u_pick_prio (
    .req(pr_req_s), .ptr(rr_ptr_r), .grant_oh(pr_oh_s), .grant_idx(pr_idx_s)
  );

  rr_pick #(.N(NUM_SRC)) u_pick_all (
    .req(bus.s_tvalid), .ptr(rr_ptr_r), .grant_oh(all_oh_s), .grant_idx(all_idx_s)
  );

  assign win_oh_s  = (|pr_req_s) ? pr_oh_s  : all_oh_s;
  assign win_idx_s = (|pr_req_s) ? pr_idx_s : all_idx_s;

  assign g_valid_s  = bus.s_tvalid[grant_idx_r];
  assign g_last_s   = bus.s_tlast[grant_idx_r];
  assign xfer_s     = (state_r == ST_FWD) && g_valid_s && bus.eth_tready;
  // Only a non-final beat at the limit aborts, so a frame of exactly MAX_BEATS passes.
  assign at_limit_s = (beat_cnt_r == LAST_BEAT) && !g_last_s;

  // State register.
  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state_r <= ST_ARB;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a grant is never preempted until tlast or abort drain ends.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_ARB:   state_s = any_req_s ? ST_FWD : ST_ARB;
      ST_FWD: begin
        if (xfer_s && g_last_s) begin
          state_s = ST_ARB;
        end else if (xfer_s && at_limit_s) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_FWD;
        end
      end
      ST_DRAIN: state_s = (g_valid_s && g_last_s) ? ST_ARB : ST_DRAIN;
      default:  state_s = ST_ARB;
    endcase
  end

  // Output mux: pass-through in FWD, silent accept in DRAIN, idle in ARB.
  always_comb begin
    bus.eth_tvalid = 1'b0;
    bus.eth_tlast  = 1'b0;
    bus.eth_tuser  = 1'b0;
    bus.eth_tkeep  = 8'h00;
    bus.eth_tdata  = 64'h0;
    bus.s_tready   = '0;
    case (state_r)
      ST_FWD: begin
        bus.eth_tvalid = g_valid_s;
        bus.eth_tdata  = bus.s_tdata[int'(grant_idx_r) * 64 +: 64];
        bus.eth_tkeep  = bus.s_tkeep[int'(grant_idx_r) * 8 +: 8];
        bus.eth_tlast  = g_last_s | (g_valid_s & at_limit_s);
        bus.eth_tuser  = g_valid_s & at_limit_s;
        bus.s_tready   = gnt_oh_r & {NUM_SRC{bus.eth_tready}};
      end
      ST_DRAIN: bus.s_tready = gnt_oh_r;
      default:  bus.s_tready = '0;
    endcase
  end

  // Grant, round-robin pointer, beat counter and abort statistics.
  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      grant_idx_r   <= '0;
      rr_ptr_r      <= ETH_TX_IDX_W'(NUM_SRC - 1);
      gnt_oh_r      <= '0;
      beat_cnt_r    <= 9'd0;
      abort_count_r <= 16'd0;
    end else begin
      if ((state_r == ST_ARB) && any_req_s) begin
        grant_idx_r <= win_idx_s;
        rr_ptr_r    <= win_idx_s;
        gnt_oh_r    <= win_oh_s;
      end
      if (xfer_s) begin
        beat_cnt_r <= (g_last_s || at_limit_s) ? 9'd0 : beat_cnt_r + 9'd1;
      end
      if (xfer_s && at_limit_s) begin
        abort_count_r <= sat_inc16(abort_count_r);
      end
    end
  end

  assign grant_idx   = grant_idx_r;
  assign abort_count = abort_count_r;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter; MAX_BEATS=6 so a 6-beat frame sits exactly
// on the limit and a 10-beat frame is aborted on beat 6.
module tb_eth_tx_arbiter;
  import nettlp_pkg::*;

  localparam int NS   = 3;
  localparam int MAXB = 6;

  logic        eth_clk = 1'b0;
  logic        eth_rst;
  logic [1:0]  grant_idx;
  logic [15:0] abort_count;

  eth_tx_arbiter_if #(.NUM_SRC(NS)) bus ();

  eth_tx_arbiter #(.NUM_SRC(NS), .PRIO_MASK(3'b010), .MAX_BEATS(MAXB)) dut (
    .eth_clk(eth_clk), .eth_rst(eth_rst), .bus(bus),
    .grant_idx(grant_idx), .abort_count(abort_count)
  );

  always #5 eth_clk = ~eth_clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        last;
    logic        user;
    logic [1:0]  gi;
    int          cyc;
  } beat_t;

  beat_t         log_q[$];
  int            sb[NS], slen[NS], fr[NS], fn[NS];
  logic [NS-1:0] gap;
  bit            rnd;
  int            cyc, drained, n_checks, n_pass, n_fail;
  int            c0, f0, f2, fno;

  function automatic logic [63:0] pat(input int src, input int fnum, input int b);
    return 64'hC0DE_0000_0000_0000 | (64'(src) << 40) | (64'(fnum) << 16) | 64'(b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NS; i++) begin
      bus.s_tvalid[i]         = (fr[i] > 0) && !gap[i];
      bus.s_tlast[i]          = (sb[i] == slen[i] - 1);
      bus.s_tkeep[8*i +: 8]   = (sb[i] == slen[i] - 1) ? 8'h0F : 8'hFF;
      bus.s_tdata[64*i +: 64] = pat(i, fn[i], sb[i]);
    end
  endtask

  task automatic settle();
    apply();
    #1;
  endtask

  // One clock: sample handshakes settled before the edge, then advance the sources.
  task automatic tick();
    logic [NS-1:0] hs;
    beat_t e;
    hs = bus.s_tvalid & bus.s_tready;
    if (bus.eth_tvalid && bus.eth_tready) begin
      e.d = bus.eth_tdata; e.k = bus.eth_tkeep; e.last = bus.eth_tlast;
      e.user = bus.eth_tuser; e.gi = grant_idx; e.cyc = cyc;
      log_q.push_back(e);
    end
    if (!bus.eth_tvalid) drained += $countones(hs);
    @(posedge eth_clk);
    #2;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (sb[i] == slen[i] - 1) begin
          sb[i] = 0; fr[i]--; fn[i]++;
        end else begin
          sb[i]++;
        end
      end
    end
    if (rnd) begin
      bus.eth_tready = 1'($urandom_range(0, 1));
      gap[1]         = ($urandom_range(0, 3) == 0);
    end
    settle();
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(log_q.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input int idx, input int src, input int fnum,
                          input int b, input int len, input logic last, input logic user);
    beat_t e;
    logic [63:0] exp_ctl;
    e = '{d: 64'h0, k: 8'h00, last: 1'b0, user: 1'b0, gi: 2'd0, cyc: 0};
    if (idx < log_q.size()) e = log_q[idx];
    exp_ctl = 64'({2'(src), last, user, ((b == len - 1) ? 8'h0F : 8'hFF)});
    chk({tag, "_data"}, e.d, pat(src, fnum, b));
    chk({tag, "_ctl"}, 64'({e.gi, e.last, e.user, e.k}), exp_ctl);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0; drained = 0;
    for (int i = 0; i < NS; i++) begin
      sb[i] = 0; slen[i] = 1; fr[i] = 0; fn[i] = 0;
    end
    gap = '0; rnd = 1'b0;
    bus.eth_tready = 1'b0;
    eth_rst = 1'b1;
    settle();
    repeat (3) tick();

    // Reset state
    chk("rst_mac", 64'({bus.eth_tvalid, bus.eth_tlast, bus.eth_tuser, bus.eth_tkeep}), 64'h0);
    chk("rst_data", bus.eth_tdata, 64'h0);
    chk("rst_srdy", 64'(bus.s_tready), 64'h0);
    chk("rst_gidx", 64'(grant_idx), 64'h0);
    chk("rst_abort", 64'(abort_count), 64'h0);
    eth_rst = 1'b0;
    bus.eth_tready = 1'b1;
    tick();

    // Six-beat frame from source 0, exactly at the beat limit
    fr[ETH_TX_SRC_TLP] = 1; slen[ETH_TX_SRC_TLP] = 6;
    settle();
    c0 = cyc;
    chk("t1_arb_idle", 64'(bus.eth_tvalid), 64'h0);
    log_q.delete();
    wait_log("t1_len", 6, 30);
    chk("t1_latency", 64'(log_q[0].cyc), 64'(c0 + 1));
    for (int b = 0; b < 6; b++) chk_beat("t1_beat", b, 0, 0, b, 6, (b == 5), 1'b0);
    chk("t1_abort", 64'(abort_count), 64'h0);

    // Sources 0 and 2 back-to-back, 3-beat frames: expect 2,0,2,0 with one idle cycle
    log_q.delete();
    f0 = fn[0]; f2 = fn[2];
    fr[0] = 2; slen[0] = 3; fr[2] = 2; slen[2] = 3;
    settle();
    wait_log("t2_len", 12, 80);
    for (int f = 0; f < 4; f++) begin
      fno = ((f % 2) == 0) ? f2 + f / 2 : f0 + f / 2;
      for (int b = 0; b < 3; b++)
        chk_beat("t2_beat", 3 * f + b, ((f % 2) == 0) ? 2 : 0, fno, b, 3, (b == 2), 1'b0);
      if (f > 0) chk("t2_gap", 64'(log_q[3*f].cyc - log_q[3*f-1].cyc), 64'd2);
    end

    // Sources 0 and 1 together: priority source 1 first
    log_q.delete();
    f0 = fn[0];
    fr[0] = 1; slen[0] = 2; fr[1] = 1; slen[1] = 2;
    settle();
    wait_log("t3a_len", 4, 30);
    for (int b = 0; b < 2; b++) chk_beat("t3a_prio", b, 1, 0, b, 2, (b == 1), 1'b0);
    for (int b = 0; b < 2; b++) chk_beat("t3a_norm", 2 + b, 0, f0, b, 2, (b == 1), 1'b0);

    // Priority request mid-frame must not preempt source 0
    log_q.delete();
    f0 = fn[0];
    fr[0] = 1; slen[0] = 4;
    settle();
    wait_log("t3b_pre", 2, 20);
    fr[1] = 1; slen[1] = 2;
    settle();
    wait_log("t3b_len", 6, 40);
    for (int b = 0; b < 4; b++) chk_beat("t3b_hold", b, 0, f0, b, 4, (b == 3), 1'b0);
    chk("t3b_contig", 64'(log_q[3].cyc - log_q[0].cyc), 64'd3);
    chk_beat("t3b_next", 4, 1, 1, 0, 2, 1'b0, 1'b0);
    chk("t3b_gap", 64'(log_q[4].cyc - log_q[3].cyc), 64'd2);

    // Ten-beat frame: aborted on beat 6, remaining 4 beats drained silently
    log_q.delete();
    drained = 0;
    f0 = fn[0];
    fr[0] = 1; slen[0] = 10;
    settle();
    wait_log("t4_len", 6, 30);
    for (int b = 0; b < 6; b++) chk_beat("t4_beat", b, 0, f0, b, 10, (b == 5), (b == 5));
    for (int k = 0; k < 30 && fr[0] > 0; k++) tick();
    chk("t4_drain_done", 64'(fr[0]), 64'h0);
    chk("t4_drained", 64'(drained), 64'd4);
    chk("t4_no_out", 64'(log_q.size()), 64'd6);
    chk("t4_abort", 64'(abort_count), 64'd1);
    log_q.delete();
    f2 = fn[2];
    fr[2] = 1; slen[2] = 2;
    settle();
    wait_log("t4b_len", 2, 20);
    for (int b = 0; b < 2; b++) chk_beat("t4b_beat", b, 2, f2, b, 2, (b == 1), 1'b0);
    chk("t4b_abort", 64'(abort_count), 64'd1);

    // Random MAC stalls and source gaps on a limit-length frame: no abort
    log_q.delete();
    fr[1] = 1; slen[1] = 6;
    rnd = 1'b1;
    settle();
    wait_log("t5_len", 6, 400);
    rnd = 1'b0; gap = '0; bus.eth_tready = 1'b1;
    settle();
    for (int b = 0; b < 6; b++) chk_beat("t5_beat", b, 1, 2, b, 6, (b == 5), 1'b0);
    chk("t5_abort", 64'(abort_count), 64'd1);

    // Reset on beat 3 of a frame
    log_q.delete();
    fr[0] = 1; slen[0] = 6;
    settle();
    wait_log("t6_pre", 2, 20);
    eth_rst = 1'b1;
    tick();
    chk("t6_mac", 64'({bus.eth_tvalid, bus.eth_tlast, bus.eth_tuser, bus.eth_tkeep}), 64'h0);
    chk("t6_data", bus.eth_tdata, 64'h0);
    chk("t6_srdy", 64'(bus.s_tready), 64'h0);
    chk("t6_gidx", 64'(grant_idx), 64'h0);
    chk("t6_abort", 64'(abort_count), 64'h0);
    fr[0] = 0; sb[0] = 0; fn[0]++;
    eth_rst = 1'b0;
    log_q.delete();
    f2 = fn[2];
    fr[2] = 1; slen[2] = 3;
    settle();
    c0 = cyc;
    wait_log("t6_len", 3, 20);
    chk("t6_latency", 64'(log_q[0].cyc), 64'(c0 + 1));
    for (int b = 0; b < 3; b++) chk_beat("t6_beat", b, 2, f2, b, 3, (b == 2), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
